// File: rtl/bus_timer_pkg.sv
// Shared register map and control-bit layout for the memory-mapped bus timer.
package bus_timer_pkg;

    typedef enum logic [1:0] {
        OFF_CTRL   = 2'd0,
        OFF_LOAD   = 2'd1,
        OFF_COUNT  = 2'd2,
        OFF_STATUS = 2'd3
    } reg_off_e;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_IRQEN = 2;
    localparam int STAT_FLAG  = 0;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w             = '0;
        w[CTRL_EN]    = c.en;
        w[CTRL_AUTO]  = c.auto_reload;
        w[CTRL_IRQEN] = c.irq_en;
        return w;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE clocks while enabled.
module tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic tick
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    // Disabling discards any partial period so a re-enable starts a full one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
        end else if (!en || pcnt == LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign tick = en && (pcnt == LAST);

endmodule

// File: rtl/bus_timer.sv
// Down-counting bus timer with auto-reload / one-shot modes and a W1C expire flag.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int PRESCALE  = 50000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wr,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic [31:0] raddr,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    ctrl_t                ctrl;
    logic [CNT_WIDTH-1:0] load_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 flag;
    logic                 tick;
    logic                 expire;
    reg_off_e             wsel;
    reg_off_e             rsel;
    logic                 wr_ctrl;
    logic                 wr_load;
    logic                 wr_count;
    logic                 wr_status;
    logic                 unused_bits;

    assign wsel      = reg_off_e'(waddr[3:2]);
    assign rsel      = reg_off_e'(raddr[3:2]);
    assign wr_ctrl   = wr && (wsel == OFF_CTRL);
    assign wr_load   = wr && (wsel == OFF_LOAD);
    assign wr_count  = wr && (wsel == OFF_COUNT);
    assign wr_status = wr && (wsel == OFF_STATUS);
    assign expire    = tick && (count_q == CNT_ONE);
    assign unused_bits = &{1'b0, waddr[31:4], waddr[1:0], raddr[31:4], raddr[1:0], wdata};

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .en   (ctrl.en),
        .tick (tick)
    );

    // A bus write to CTRL wins over the one-shot self-disable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl.en          <= wdata[CTRL_EN];
            ctrl.auto_reload <= wdata[CTRL_AUTO];
            ctrl.irq_en      <= wdata[CTRL_IRQEN];
        end else if (expire && !ctrl.auto_reload) begin
            ctrl.en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_q <= '0;
        end else if (wr_load) begin
            load_q <= wdata[CNT_WIDTH-1:0];
        end
    end

    // A bus write to COUNT wins over the tick update on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (wr_count) begin
            count_q <= wdata[CNT_WIDTH-1:0];
        end else if (tick) begin
            if (count_q == CNT_ONE) begin
                count_q <= ctrl.auto_reload ? load_q : '0;
            end else if (count_q != '0) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    // Setting on expire wins over a same-edge W1C clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flag <= 1'b0;
        end else if (expire) begin
            flag <= 1'b1;
        end else if (wr_status && wdata[STAT_FLAG]) begin
            flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (rd) begin
            case (rsel)
                OFF_CTRL:   rdata <= ctrl_word(ctrl);
                OFF_LOAD:   rdata <= 32'(load_q);
                OFF_COUNT:  rdata <= 32'(count_q);
                OFF_STATUS: rdata <= {31'd0, flag};
                default:    rdata <= '0;
            endcase
        end
    end

    assign irq = flag && ctrl.irq_en;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: register vector table plus timed multi-cycle sequences.
module tb_bus_timer;

    logic        clk;
    logic        rstn;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        irq;
    logic [31:0] rdata32;
    logic        irq32;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp8;
        logic [31:0] exp32;
    } vec_t;

    vec_t vecs[8];

    bus_timer #(.CNT_WIDTH(8), .PRESCALE(4)) u_dut (
        .clk   (clk),
        .rstn  (rstn),
        .wr    (wr),
        .waddr (waddr),
        .wdata (wdata),
        .rd    (rd),
        .raddr (raddr),
        .rdata (rdata),
        .irq   (irq)
    );

    bus_timer #(.CNT_WIDTH(32), .PRESCALE(4)) u_dut32 (
        .clk   (clk),
        .rstn  (rstn),
        .wr    (wr),
        .waddr (waddr),
        .wdata (wdata),
        .rd    (rd),
        .raddr (raddr),
        .rdata (rdata32),
        .irq   (irq32)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: called at a negedge, return at the next negedge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        rd = 1'b1; raddr = a;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] auto_exp(input int j);
        int m;
        m = j % 12;
        if (m < 4) return 32'd3;
        if (m < 8) return 32'd2;
        return 32'd1;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0; wr = 1'b0; rd = 1'b0;
        waddr = '0; wdata = '0; raddr = '0;

        vecs[0] = '{"ctrl_bits",    32'h0,  32'hFFFF_FFF6, 32'h0,  32'h6,  32'h6};
        vecs[1] = '{"ctrl_alias",   32'h13, 32'h4,         32'h0,  32'h4,  32'h4};
        vecs[2] = '{"load_trunc",   32'h4,  32'hFFFF_FF12, 32'h4,  32'h12, 32'hFFFF_FF12};
        vecs[3] = '{"load_alias",   32'h4,  32'hA5,        32'hF5, 32'hA5, 32'hA5};
        vecs[4] = '{"count_direct", 32'h8,  32'h1234_5677, 32'h8,  32'h77, 32'h1234_5677};
        vecs[5] = '{"status_w1c0",  32'hC,  32'h1,         32'hC,  32'h0,  32'h0};
        vecs[6] = '{"count_zero",   32'h8,  32'h0,         32'hB,  32'h0,  32'h0};
        vecs[7] = '{"ctrl_clear",   32'h0,  32'h0,         32'h0,  32'h0,  32'h0};

        repeat (3) @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // Register vector table
        foreach (vecs[i]) begin
            bus_write(vecs[i].waddr, vecs[i].wdata);
            bus_read(vecs[i].raddr);
            check({vecs[i].name, "_w8"}, rdata, vecs[i].exp8);
            check({vecs[i].name, "_w32"}, rdata32, vecs[i].exp32);
            check({vecs[i].name, "_irq"}, {31'd0, irq}, 32'h0);
        end

        // Auto-reload: continuous COUNT reads, flag cleared at E15, second expire at E24
        bus_write(32'h4, 32'd3);
        bus_write(32'h8, 32'd3);
        bus_write(32'h0, 32'h7);
        rd = 1'b1; raddr = 32'h8;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            check($sformatf("auto_count_k%0d", k), rdata, auto_exp(k - 1));
            check($sformatf("auto_irq_k%0d", k), {31'd0, irq},
                  ((k >= 12 && k < 15) || k >= 24) ? 32'h1 : 32'h0);
            if (k == 14) begin
                wr = 1'b1; waddr = 32'hC; wdata = 32'h1;
            end else begin
                wr = 1'b0;
            end
        end
        rd = 1'b0; wr = 1'b0;
        bus_write(32'h0, 32'h0);
        bus_write(32'hC, 32'h1);

        // One-shot: expire at E8 clears en
        bus_write(32'h8, 32'd2);
        bus_write(32'h0, 32'h1);
        repeat (7) @(negedge clk);
        bus_read(32'hC);
        check("oneshot_flag_pre", rdata, 32'h0);
        bus_read(32'hC);
        check("oneshot_flag_set", rdata, 32'h1);
        bus_read(32'h0);
        check("oneshot_ctrl", rdata, 32'h0);
        bus_read(32'h8);
        check("oneshot_count", rdata, 32'h0);
        repeat (10) @(negedge clk);
        bus_read(32'h8);
        check("oneshot_count_stays", rdata, 32'h0);
        check("oneshot_irq_masked", {31'd0, irq}, 32'h0);
        bus_write(32'hC, 32'h1);

        // W1C collides with the expire edge E4
        bus_write(32'h8, 32'd1);
        bus_write(32'h0, 32'h5);
        repeat (3) @(negedge clk);
        bus_write(32'hC, 32'h1);
        check("w1c_collide_irq", {31'd0, irq}, 32'h1);
        bus_read(32'hC);
        check("w1c_collide_flag", rdata, 32'h1);
        bus_write(32'hC, 32'h0);
        bus_read(32'hC);
        check("w1c_zero_noop", rdata, 32'h1);
        bus_write(32'hC, 32'h1);
        bus_read(32'hC);
        check("w1c_clear", rdata, 32'h0);
        check("w1c_clear_irq", {31'd0, irq}, 32'h0);
        bus_read(32'h0);
        check("w1c_ctrl_after", rdata, 32'h4);
        bus_write(32'h0, 32'h0);

        // COUNT write on the tick edge E4, then read hold while counting
        bus_write(32'h8, 32'h30);
        bus_write(32'h0, 32'h1);
        repeat (3) @(negedge clk);
        bus_write(32'h8, 32'h55);
        bus_read(32'h8);
        check("wr_beats_tick", rdata, 32'h55);
        rd = 1'b1; raddr = 32'h8;
        @(negedge clk);
        rd = 1'b0;
        for (int k = 7; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("rdata_hold_k%0d", k), rdata, 32'h55);
        end
        bus_read(32'h8);
        check("rdata_refresh", rdata, 32'h53);
        bus_write(32'h0, 32'h0);

        // Same-cycle read and write of COUNT returns the old value
        bus_write(32'h8, 32'h21);
        wr = 1'b1; waddr = 32'h8; wdata = 32'h42;
        rd = 1'b1; raddr = 32'h8;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        check("rdwr_old", rdata, 32'h21);
        bus_read(32'h8);
        check("rdwr_new", rdata, 32'h42);

        // Asynchronous reset while counting with flag and irq up
        bus_write(32'h4, 32'd5);
        bus_write(32'h8, 32'd1);
        bus_write(32'h0, 32'h7);
        repeat (6) @(negedge clk);
        check("prereset_irq", {31'd0, irq}, 32'h1);
        #2 rstn = 1'b0;
        #1;
        check("async_reset_irq", {31'd0, irq}, 32'h0);
        check("async_reset_rdata", rdata, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(32'(a * 4));
            check($sformatf("reset_read_off%0d", a * 4), rdata, 32'h0);
            check($sformatf("reset_read32_off%0d", a * 4), rdata32, 32'h0);
        end
        check("reset_irq_after", {31'd0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
